// File: rtl/spm_bus_pkg.sv
// Shared definitions for the 8-bit processor bus: destination codes used by
// both the source-side mux and the destination-side load demux, plus the
// load-unit FSM state encoding.
package spm_bus_pkg;

    localparam int SEL_W_DEF    = 3;
    localparam int NUM_DEST_DEF = 5;

    // Destination codes, identical to the bus mux select encoding
    localparam logic [SEL_W_DEF-1:0] SEL_R0 = 3'd0;
    localparam logic [SEL_W_DEF-1:0] SEL_R1 = 3'd1;
    localparam logic [SEL_W_DEF-1:0] SEL_R2 = 3'd2;
    localparam logic [SEL_W_DEF-1:0] SEL_R3 = 3'd3;
    localparam logic [SEL_W_DEF-1:0] SEL_PC = 3'd4;

    // Load-unit FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

endpackage

// File: rtl/bus_load_demux_dest_reg.sv
// One destination register: synchronous reset, parallel load and +1
// increment. A load in the same cycle as an increment wins.
module dest_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load_en,
    input  logic             inc_en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Register update: reset, then load, then increment, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {WIDTH{1'b0}};
        end else if (load_en) begin
            q_r <= d;
        end else if (inc_en) begin
            q_r <= q_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/bus_load_demux.sv
// Destination end of the processor bus. A word/select pair is accepted with
// a valid/ready handshake, held in capture registers, and written into the
// selected destination register one cycle later. Illegal selects produce a
// one-cycle sel_err pulse instead of a write. The PC destination also
// supports increment.
module bus_load_demux
    import spm_bus_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_DEST = NUM_DEST_DEF,
    parameter int SEL_W    = SEL_W_DEF,
    parameter int PC_IDX   = int'(SEL_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [SEL_W-1:0] sel,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             inc_pc,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic             sel_err,
    output logic [7:0]       load_count
);

    // True when the code addresses an existing destination
    function automatic logic sel_is_legal(input logic [SEL_W-1:0] s);
        return ({1'b0, s} < (SEL_W+1)'(NUM_DEST));
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic                  ready_r;
    logic                  sel_err_r;
    logic [7:0]            load_count_r;
    logic [WIDTH-1:0]      cap_data_r;
    logic [SEL_W-1:0]      cap_sel_r;
    logic                  accept_s;
    logic [NUM_DEST-1:0]   load_en_s;
    logic [WIDTH-1:0]      dest_q_s [NUM_DEST];

    // ready_r is only ever high in IDLE, so it alone qualifies an accept
    assign accept_s = load_valid & ready_r;

    // Next-state logic: IDLE waits for an accept, COMMIT and ERR last one cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (sel_is_legal(sel)) begin
                        state_s = ST_COMMIT;
                    end else begin
                        state_s = ST_ERR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            ST_ERR:    state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register with registered ready / error flags derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ready_r   <= 1'b0;
            sel_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ready_r   <= (state_s == ST_IDLE);
            sel_err_r <= (state_s == ST_ERR);
        end
    end

    // Capture the bus word and select only at the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_data_r <= {WIDTH{1'b0}};
            cap_sel_r  <= {SEL_W{1'b0}};
        end else if (accept_s) begin
            cap_data_r <= bus_in;
            cap_sel_r  <= sel;
        end else begin
            cap_data_r <= cap_data_r;
            cap_sel_r  <= cap_sel_r;
        end
    end

    // Count committed loads; wraps naturally at 8 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            load_count_r <= 8'd0;
        end else if (state_r == ST_COMMIT) begin
            load_count_r <= load_count_r + 8'd1;
        end else begin
            load_count_r <= load_count_r;
        end
    end

    // Select decoder: one-hot write enable during COMMIT only
    always_comb begin
        load_en_s = {NUM_DEST{1'b0}};
        if (state_r == ST_COMMIT) begin
            for (int i = 0; i < NUM_DEST; i++) begin
                if (cap_sel_r == SEL_W'(i)) begin
                    load_en_s[i] = 1'b1;
                end else begin
                    load_en_s[i] = 1'b0;
                end
            end
        end else begin
            load_en_s = {NUM_DEST{1'b0}};
        end
    end

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
        dest_reg #(
            .WIDTH (WIDTH)
        ) u_dest_reg (
            .clk     (clk),
            .rst     (rst),
            .d       (cap_data_r),
            .load_en (load_en_s[g]),
            .inc_en  ((g == PC_IDX) ? inc_pc : 1'b0),
            .q       (dest_q_s[g])
        );
    end

    assign load_ready = ready_r;
    assign sel_err    = sel_err_r;
    assign load_count = load_count_r;
    assign out0       = dest_q_s[0];
    assign out1       = dest_q_s[1];
    assign out2       = dest_q_s[2];
    assign out3       = dest_q_s[3];
    assign out4       = dest_q_s[4];

endmodule
